// File: rtl/z80_bus_ctrl.sv
// Z80 bus companion: wait-state generator, IM2 vectored interrupt controller
// with edge-latched pending bits, and a fixed-width NMI pulse generator.
module z80_bus_ctrl #(
    parameter int         NUM_IRQ   = 4,
    parameter int         MEM_WAIT  = 0,
    parameter int         IO_WAIT   = 1,
    parameter logic [7:0] VEC_BASE  = 8'hE0,
    parameter int         NMI_PULSE = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               M1_N,
    input  logic               MREQ_N,
    input  logic               IORQ_N,
    input  logic               RD_N,
    input  logic               WR_N,
    input  logic               RFSH_N,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic [NUM_IRQ-1:0] IRQ_EN,
    input  logic               NMI_IN,
    output logic               WAIT_N,
    output logic               INT_N,
    output logic               NMI_N,
    output logic [7:0]         VEC_OUT,
    output logic               VEC_OE,
    output logic [NUM_IRQ-1:0] IRQ_PEND
);

    localparam logic [2:0] MEM_CNT = 3'(MEM_WAIT);
    localparam logic [2:0] IO_CNT  = 3'(IO_WAIT);
    localparam logic [3:0] NMI_CNT = 4'(NMI_PULSE);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_wcnt;
    logic [NUM_IRQ-1:0] r_irq_q;
    logic               r_nmi_q;
    logic               r_mreq_q;
    logic               r_iorq_q;
    logic               r_armed;
    logic [NUM_IRQ-1:0] r_pend;
    logic               r_int_n;
    logic               r_ack_act;
    logic [2:0]         r_ack_idx;
    logic [NUM_IRQ-1:0] r_ack_mask;
    logic [3:0]         r_nmi_cnt;

    logic               w_armed;
    logic               w_rw;
    logic               w_mem_acc;
    logic               w_io_acc;
    logic               w_detect;
    logic [2:0]         w_det_cnt;
    logic [NUM_IRQ-1:0] w_act;
    logic [2:0]         w_k;
    logic [NUM_IRQ-1:0] w_k_mask;
    logic               w_ack_start;
    logic               w_ack_end;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_irq_rise;
    logic               w_nmi_rise;

    // Input sampling; the bus is only armed once both strobes were seen high
    // after reset, so an access torn by reset is never picked up half-way.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_irq_q  <= '0;
            r_nmi_q  <= 1'b0;
            r_mreq_q <= 1'b0;
            r_iorq_q <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_irq_q  <= IRQ;
            r_nmi_q  <= NMI_IN;
            r_mreq_q <= MREQ_N;
            r_iorq_q <= IORQ_N;
            r_armed  <= w_armed;
        end
    end

    assign w_armed    = r_armed | (r_mreq_q & r_iorq_q);
    assign w_rw       = ~RD_N | ~WR_N;
    assign w_mem_acc  = w_armed & ~MREQ_N & RFSH_N & w_rw;
    assign w_io_acc   = w_armed & ~IORQ_N & M1_N & w_rw;
    assign w_detect   = w_mem_acc | w_io_acc;
    assign w_det_cnt  = w_mem_acc ? MEM_CNT : IO_CNT;
    assign w_irq_rise = IRQ & ~r_irq_q;
    assign w_nmi_rise = NMI_IN & ~r_nmi_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_detect) begin
                    w_state_nxt = (w_det_cnt != 3'd0) ? ST_WAIT : ST_HOLD;
                end
            end
            ST_WAIT: begin
                if (r_wcnt <= 3'd1) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (MREQ_N && IORQ_N) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        WAIT_N = (r_state != ST_WAIT);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wcnt <= 3'd0;
        end else if (r_state == ST_IDLE && w_detect) begin
            r_wcnt <= w_det_cnt;
        end else if (r_state == ST_WAIT && r_wcnt != 3'd0) begin
            r_wcnt <= r_wcnt - 3'd1;
        end
    end

    // Lowest-numbered enabled pending channel; an empty mask marks a spurious ack.
    assign w_act = r_pend & IRQ_EN;

    always_comb begin
        w_k      = 3'd7;
        w_k_mask = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                w_k         = 3'(i);
                w_k_mask    = '0;
                w_k_mask[i] = 1'b1;
            end
        end
    end

    assign w_ack_start = ~r_ack_act & ~M1_N & ~IORQ_N & w_armed;
    assign w_ack_end   = r_ack_act & IORQ_N;
    assign w_clr       = w_ack_end ? r_ack_mask : '0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pend     <= '0;
            r_int_n    <= 1'b1;
            r_ack_act  <= 1'b0;
            r_ack_idx  <= 3'd0;
            r_ack_mask <= '0;
        end else begin
            // A new edge on the channel being cleared keeps it pending.
            r_pend  <= (r_pend & ~w_clr) | w_irq_rise;
            r_int_n <= ~|w_act;
            if (w_ack_start) begin
                r_ack_act  <= 1'b1;
                r_ack_idx  <= w_k;
                r_ack_mask <= w_k_mask;
            end else if (w_ack_end) begin
                r_ack_act  <= 1'b0;
            end
        end
    end

    assign INT_N    = r_int_n;
    assign IRQ_PEND = r_pend;
    assign VEC_OE   = r_ack_act;
    assign VEC_OUT  = r_ack_act ? (VEC_BASE + {4'b0000, r_ack_idx, 1'b0}) : 8'h00;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_nmi_cnt <= 4'd0;
        end else if (r_nmi_cnt != 4'd0) begin
            r_nmi_cnt <= r_nmi_cnt - 4'd1;
        end else if (w_nmi_rise) begin
            r_nmi_cnt <= NMI_CNT;
        end
    end

    assign NMI_N = (r_nmi_cnt == 4'd0);

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Bench for z80_bus_ctrl: two instances with different wait/vector/NMI settings
// share one set of inputs and are compared each cycle against a timestamp model.
module tb_z80_bus_ctrl;

    localparam int         MEM0  = 0;
    localparam int         IO0   = 3;
    localparam int         NP0   = 4;
    localparam logic [7:0] BASE0 = 8'hE0;
    localparam int         MEM1  = 2;
    localparam int         IO1   = 0;
    localparam int         NP1   = 1;
    localparam logic [7:0] BASE1 = 8'hF8;

    logic       clk;
    logic       rst;
    logic       m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [3:0] irq;
    logic [3:0] irq_en;
    logic       nmi_in;

    logic       wait_n  [2];
    logic       int_n   [2];
    logic       nmi_n   [2];
    logic [7:0] vec_out [2];
    logic       vec_oe  [2];
    logic [3:0] pend    [2];

    int n_checks = 0;
    int n_err    = 0;

    z80_bus_ctrl #(
        .NUM_IRQ(4), .MEM_WAIT(MEM0), .IO_WAIT(IO0), .VEC_BASE(BASE0), .NMI_PULSE(NP0)
    ) dut0 (
        .CLK(clk), .RESET(rst), .M1_N(m1_n), .MREQ_N(mreq_n), .IORQ_N(iorq_n),
        .RD_N(rd_n), .WR_N(wr_n), .RFSH_N(rfsh_n), .IRQ(irq), .IRQ_EN(irq_en),
        .NMI_IN(nmi_in), .WAIT_N(wait_n[0]), .INT_N(int_n[0]), .NMI_N(nmi_n[0]),
        .VEC_OUT(vec_out[0]), .VEC_OE(vec_oe[0]), .IRQ_PEND(pend[0])
    );

    z80_bus_ctrl #(
        .NUM_IRQ(4), .MEM_WAIT(MEM1), .IO_WAIT(IO1), .VEC_BASE(BASE1), .NMI_PULSE(NP1)
    ) dut1 (
        .CLK(clk), .RESET(rst), .M1_N(m1_n), .MREQ_N(mreq_n), .IORQ_N(iorq_n),
        .RD_N(rd_n), .WR_N(wr_n), .RFSH_N(rfsh_n), .IRQ(irq), .IRQ_EN(irq_en),
        .NMI_IN(nmi_in), .WAIT_N(wait_n[1]), .INT_N(int_n[1]), .NMI_N(nmi_n[1]),
        .VEC_OUT(vec_out[1]), .VEC_OE(vec_oe[1]), .IRQ_PEND(pend[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: access/ack/pulse events recorded as edge timestamps.
    int         n_edge = 0;
    logic [3:0] m_pend   [2];
    bit         m_int_n  [2];
    bit         m_ack    [2];
    int         m_k      [2];
    logic [3:0] m_kmask  [2];
    bit         m_acc    [2];
    int         m_det    [2];
    int         m_cnt    [2];
    int         m_nmi_s  [2];
    logic [3:0] m_irq_prev;
    bit         m_nmi_prev;
    bit         m_armed;

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 4'h0; m_int_n[d] = 1'b1; m_ack[d] = 1'b0; m_k[d] = 0;
            m_kmask[d] = 4'h0; m_acc[d] = 1'b0; m_det[d] = 0; m_cnt[d] = 0;
            m_nmi_s[d] = -100;
        end
        m_irq_prev = 4'h0; m_nmi_prev = 1'b0; m_armed = 1'b0;
    endfunction

    function automatic void model_edge();
        bit         both_hi, rw, mem, io, found;
        int         mw, iw, np, kk;
        logic [3:0] act, km, clr;
        both_hi = mreq_n && iorq_n;
        rw      = !rd_n || !wr_n;
        n_edge++;
        for (int d = 0; d < 2; d++) begin
            mw  = (d == 0) ? MEM0 : MEM1;
            iw  = (d == 0) ? IO0 : IO1;
            np  = (d == 0) ? NP0 : NP1;
            mem = m_armed && !mreq_n && rfsh_n && rw;
            io  = m_armed && !iorq_n && m1_n && rw;
            act = m_pend[d] & irq_en;
            kk = 7; km = 4'h0; found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!found && act[i]) begin
                    kk = i; km = 4'h0; km[i] = 1'b1; found = 1'b1;
                end
            end
            clr = 4'h0;
            if (m_acc[d]) begin
                if (n_edge >= m_det[d] + m_cnt[d] + 1 && both_hi) m_acc[d] = 1'b0;
            end else if (mem || io) begin
                m_acc[d] = 1'b1; m_det[d] = n_edge; m_cnt[d] = mem ? mw : iw;
            end
            if (m_ack[d]) begin
                if (iorq_n) begin clr = m_kmask[d]; m_ack[d] = 1'b0; end
            end else if (!m1_n && !iorq_n && m_armed) begin
                m_ack[d] = 1'b1; m_k[d] = kk; m_kmask[d] = km;
            end
            m_int_n[d] = (act == 4'h0);
            m_pend[d]  = (m_pend[d] & ~clr) | (irq & ~m_irq_prev);
            if (nmi_in && !m_nmi_prev &&
                !(n_edge - 1 >= m_nmi_s[d] && n_edge - 1 < m_nmi_s[d] + np))
                m_nmi_s[d] = n_edge;
        end
        m_irq_prev = irq;
        m_nmi_prev = nmi_in;
        m_armed    = m_armed || both_hi;
    endfunction

    function automatic bit exp_wait(int d);
        return !(m_acc[d] && n_edge < m_det[d] + m_cnt[d]);
    endfunction

    function automatic bit exp_nmi(int d);
        int np;
        np = (d == 0) ? NP0 : NP1;
        return !(n_edge >= m_nmi_s[d] && n_edge < m_nmi_s[d] + np);
    endfunction

    function automatic logic [7:0] exp_vec(int d);
        logic [7:0] b;
        b = (d == 0) ? BASE0 : BASE1;
        return m_ack[d] ? 8'(b + 8'(2 * m_k[d])) : 8'h00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("model wait_n[%0d]", d), 32'(wait_n[d]), 32'(exp_wait(d)));
            chk($sformatf("model int_n[%0d]", d), 32'(int_n[d]), 32'(m_int_n[d]));
            chk($sformatf("model nmi_n[%0d]", d), 32'(nmi_n[d]), 32'(exp_nmi(d)));
            chk($sformatf("model vec_oe[%0d]", d), 32'(vec_oe[d]), 32'(m_ack[d]));
            chk($sformatf("model vec_out[%0d]", d), 32'(vec_out[d]), 32'(exp_vec(d)));
            chk($sformatf("model pend[%0d]", d), 32'(pend[d]), 32'(m_pend[d]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_bus(input int t);
        {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = 6'b111111;
        case (t)
            1: begin mreq_n = 1'b0; rd_n = 1'b0; end
            2: begin mreq_n = 1'b0; wr_n = 1'b0; end
            3: begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
            4: begin mreq_n = 1'b0; rfsh_n = 1'b0; end
            5: begin iorq_n = 1'b0; rd_n = 1'b0; end
            6: begin iorq_n = 1'b0; wr_n = 1'b0; end
            7: begin m1_n = 1'b0; iorq_n = 1'b0; end
            8: {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = 6'($urandom);
            default: ;
        endcase
    endtask

    typedef struct {
        logic m1, mreq, iorq, rd, wr, rfsh;
        logic w0, w1;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] b);
        vec_t v;
        {v.m1, v.mreq, v.iorq, v.rd, v.wr, v.rfsh, v.w0, v.w1} = b;
        return v;
    endfunction

    vec_t tbl [28];
    logic [7:0] rows [28] = '{
        8'b111111_11,
        8'b110011_01, 8'b110011_01, 8'b110011_01, 8'b110011_11, 8'b110011_11, 8'b110011_11,
        8'b111111_11,
        8'b101011_10, 8'b101011_10, 8'b101011_11, 8'b101011_11,
        8'b111111_11,
        8'b101110_11, 8'b101110_11,
        8'b111111_11,
        8'b001011_10, 8'b001011_10, 8'b001011_11,
        8'b111111_11,
        8'b010111_11, 8'b010111_11,
        8'b111111_11,
        8'b110101_01, 8'b110101_01, 8'b110101_01, 8'b110101_11,
        8'b111111_11
    };

    int nmi_low;
    int nmi_falls;
    bit nmi_last;

    initial begin
        for (int i = 0; i < 28; i++) tbl[i] = mk(rows[i]);
        set_bus(0);
        irq = 4'h0; irq_en = 4'hF; nmi_in = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset wait_n", 32'(wait_n[0]), 32'(1'b1));
        chk("reset int_n", 32'(int_n[0]), 32'(1'b1));
        chk("reset nmi_n", 32'(nmi_n[0]), 32'(1'b1));
        chk("reset vec_oe", 32'(vec_oe[0]), 32'(1'b0));
        chk("reset vec_out", 32'(vec_out[0]), 32'h00);
        chk("reset pend", 32'(pend[0]), 32'h0);
        rst = 1'b0;

        // Wait-state vectors: I/O read with 3 waits, memory read/refresh/fetch, ack, I/O write.
        for (int i = 0; i < 28; i++) begin
            {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} =
                {tbl[i].m1, tbl[i].mreq, tbl[i].iorq, tbl[i].rd, tbl[i].wr, tbl[i].rfsh};
            step();
            chk($sformatf("tbl%0d wait_n[0]", i), 32'(wait_n[0]), 32'(tbl[i].w0));
            chk($sformatf("tbl%0d wait_n[1]", i), 32'(wait_n[1]), 32'(tbl[i].w1));
        end

        // Two channels rise together; acknowledged in priority order.
        do_reset(2);
        set_bus(0); irq = 4'h0; irq_en = 4'hF;
        repeat (3) step();
        irq = 4'b0110; step();
        chk("dual pend", 32'(pend[0]), 32'h6);
        step();
        chk("dual int_n", 32'(int_n[0]), 32'(1'b0));
        set_bus(7); step();
        chk("ack1 vec_oe", 32'(vec_oe[0]), 32'(1'b1));
        chk("ack1 vec_out", 32'(vec_out[0]), 32'hE2);
        chk("ack1 vec_out dut1", 32'(vec_out[1]), 32'hFA);
        step(); step();
        set_bus(0); step();
        chk("ack1 pend", 32'(pend[0]), 32'h4);
        chk("ack1 vec_oe off", 32'(vec_oe[0]), 32'(1'b0));
        step();
        set_bus(7); step();
        chk("ack2 vec_out", 32'(vec_out[0]), 32'hE4);
        step();
        set_bus(0); step();
        chk("ack2 pend", 32'(pend[0]), 32'h0);
        step();
        chk("ack2 int_n", 32'(int_n[0]), 32'(1'b1));

        // Enable of the acknowledged channel drops mid-acknowledge.
        irq = 4'h0; step();
        irq = 4'b0010; step(); step();
        set_bus(7); step();
        chk("frz vec_out a", 32'(vec_out[0]), 32'hE2);
        irq_en = 4'b1101; step();
        chk("frz vec_out b", 32'(vec_out[0]), 32'hE2);
        step();
        chk("frz vec_out c", 32'(vec_out[0]), 32'hE2);
        set_bus(0); step();
        chk("frz pend", 32'(pend[0]), 32'h0);
        chk("frz vec_oe", 32'(vec_oe[0]), 32'(1'b0));
        irq_en = 4'hF;

        // Spurious acknowledge, including 8-bit wrap of the second base.
        set_bus(7); step();
        chk("spur vec_out", 32'(vec_out[0]), 32'hEE);
        chk("spur vec_out dut1", 32'(vec_out[1]), 32'h06);
        set_bus(0); step();
        chk("spur pend", 32'(pend[0]), 32'h0);

        // New edge on the channel being cleared keeps it set.
        irq = 4'h0; step();
        irq = 4'b0001; step();
        set_bus(7); irq = 4'h0; step(); step();
        set_bus(0); irq = 4'b0001; step();
        chk("setwins pend", 32'(pend[0]), 32'h1);
        set_bus(7); step();
        set_bus(0); step();
        chk("setwins clear", 32'(pend[0]), 32'h0);

        // NMI edge plus a second edge two cycles later.
        nmi_in = 1'b0; irq = 4'h0; step(); step();
        nmi_low = 0; nmi_falls = 0; nmi_last = 1'b1;
        for (int c = 0; c < 9; c++) begin
            nmi_in = (c == 0 || c == 2) ? 1'b1 : 1'b0;
            step();
            if (!nmi_n[0]) nmi_low++;
            if (nmi_last && !nmi_n[0]) nmi_falls++;
            nmi_last = nmi_n[0];
        end
        chk("nmi low cycles", 32'(nmi_low), 32'd4);
        chk("nmi pulses", 32'(nmi_falls), 32'd1);

        // Reset during wait states with channels pending, then torn-access recovery.
        do_reset(2);
        set_bus(0); irq = 4'h0; step(); step();
        irq = 4'b0101; step();
        set_bus(5); step(); step();
        chk("pre-rst wait_n", 32'(wait_n[0]), 32'(1'b0));
        chk("pre-rst int_n", 32'(int_n[0]), 32'(1'b0));
        rst = 1'b1;
        #1;
        chk("rst wait_n", 32'(wait_n[0]), 32'(1'b1));
        chk("rst int_n", 32'(int_n[0]), 32'(1'b1));
        chk("rst pend", 32'(pend[0]), 32'h0);
        chk("rst vec_oe", 32'(vec_oe[0]), 32'(1'b0));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("torn wait_n", 32'(wait_n[0]), 32'(1'b1));
        end
        set_bus(0); step();
        set_bus(5); step();
        chk("rearm wait_n", 32'(wait_n[0]), 32'(1'b0));
        step(); step(); step();
        set_bus(0); step(); step();

        // Randomized bus traffic, interrupt and NMI activity.
        for (int it = 0; it < 600; it++) begin
            int t, len;
            t   = $urandom_range(0, 8);
            len = $urandom_range(1, 6);
            if ($urandom_range(0, 199) == 0) do_reset(2);
            for (int c = 0; c < len; c++) begin
                set_bus(t);
                if ($urandom_range(0, 3) == 0) irq[$urandom_range(0, 3)] = ~irq[$urandom_range(0, 3)];
                if ($urandom_range(0, 15) == 0) irq_en = 4'($urandom);
                if ($urandom_range(0, 4) == 0) nmi_in = ~nmi_in;
                step();
            end
            if ($urandom_range(0, 1) == 0) begin
                set_bus(0);
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
